// File: rtl/adc_sample_averager_pkg.sv
// Shared constants and types for the ADC sample averager and its neighbours
// (ADC reader width and the default 1 kHz sample divider at 12 MHz).
package adc_sample_averager_pkg;

   localparam int ADC_WIDTH      = 10;
   localparam int ADC_SAMPLE_DIV = 12000;

   typedef enum logic [0:0] {
      FILLING = 1'b0,
      FULL    = 1'b1
   } fill_state_e;

endpackage

// File: rtl/adc_sample_averager_if.sv
// Sample/clear inputs and averaged statistics outputs of the averager.
// No handshake: consumers sample the outputs whenever they like.
interface adc_sample_averager_if #(
   parameter int WIDTH = 10
);
   logic [WIDTH-1:0] value;
   logic             clear;
   logic             sample_tick;
   logic [WIDTH-1:0] avg;
   logic             avg_valid;
   logic [WIDTH-1:0] min_val;
   logic [WIDTH-1:0] max_val;

   modport master (
      output value, clear,
      input  sample_tick, avg, avg_valid, min_val, max_val
   );

   modport slave (
      input  value, clear,
      output sample_tick, avg, avg_valid, min_val, max_val
   );
endinterface

// File: rtl/adc_sample_averager_sample_ring.sv
// N x WIDTH sample history with a wrapping write pointer; the slot about to be
// overwritten is presented combinationally so the caller can retire it the same cycle.
module sample_ring #(
   parameter int WIDTH  = 10,
   parameter int LOG2_N = 4
) (
   input  logic             clk12MHz,
   input  logic             resetq,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_dat,
   output logic [WIDTH-1:0] old_dat
);
   localparam int N = 1 << LOG2_N;

   logic [WIDTH-1:0]  ring_q [N];
   logic [WIDTH-1:0]  ring_d [N];
   logic [LOG2_N-1:0] wr_ptr_q;
   logic [LOG2_N-1:0] wr_ptr_d;

   assign old_dat = ring_q[wr_ptr_q];

   always_comb begin
      for (int i = 0; i < N; i++) begin
         ring_d[i] = ring_q[i];
      end
      wr_ptr_d = wr_ptr_q;
      // Clear wins so a coincident write never lands in the fresh window.
      if (clear) begin
         for (int i = 0; i < N; i++) begin
            ring_d[i] = '0;
         end
         wr_ptr_d = '0;
      end else if (wr_en) begin
         ring_d[wr_ptr_q] = wr_dat;
         wr_ptr_d         = wr_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk12MHz or negedge resetq) begin
      if (!resetq) begin
         for (int i = 0; i < N; i++) begin
            ring_q[i] <= '0;
         end
         wr_ptr_q <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            ring_q[i] <= ring_d[i];
         end
         wr_ptr_q <= wr_ptr_d;
      end
   end
endmodule

// File: rtl/adc_sample_averager.sv
// Decimating sampler with a 2^LOG2_N boxcar average and min/max since clear.
// Outputs reflect a tick's sample one cycle after the tick; no backpressure.
module adc_sample_averager
   import adc_sample_averager_pkg::*;
#(
   parameter int WIDTH      = ADC_WIDTH,
   parameter int LOG2_N     = 4,
   parameter int SAMPLE_DIV = ADC_SAMPLE_DIV
) (
   input  logic                   clk12MHz,
   input  logic                   resetq,
   adc_sample_averager_if.slave   bus
);
   localparam int N     = 1 << LOG2_N;
   localparam int SUM_W = WIDTH + LOG2_N;
   localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

   logic [WIDTH-1:0] value_q;
   logic [DIV_W-1:0] div_cnt_q,   div_cnt_d;
   logic [SUM_W-1:0] sum_q,       sum_d;
   logic [WIDTH-1:0] min_val_q,   min_val_d;
   logic [WIDTH-1:0] max_val_q,   max_val_d;
   logic [LOG2_N-1:0] fill_cnt_q, fill_cnt_d;
   fill_state_e      state_q,     state_d;

   logic             tick;
   logic             take;
   logic [WIDTH-1:0] old_dat;

   assign tick = (div_cnt_q == DIV_W'(SAMPLE_DIV - 1));
   // A clear in the tick cycle discards that sample entirely.
   assign take = tick && !bus.clear;

   sample_ring #(
      .WIDTH  (WIDTH),
      .LOG2_N (LOG2_N)
   ) u_ring (
      .clk12MHz (clk12MHz),
      .resetq   (resetq),
      .clear    (bus.clear),
      .wr_en    (take),
      .wr_dat   (value_q),
      .old_dat  (old_dat)
   );

   always_comb begin
      div_cnt_d = div_cnt_q + 1'b1;
      if (bus.clear || tick) begin
         div_cnt_d = '0;
      end
   end

   always_comb begin
      sum_d     = sum_q;
      min_val_d = min_val_q;
      max_val_d = max_val_q;
      if (bus.clear) begin
         sum_d     = '0;
         min_val_d = '1;
         max_val_d = '0;
      end else if (take) begin
         // Intermediate may wrap, but the final window sum always fits SUM_W.
         sum_d = sum_q + SUM_W'(value_q) - SUM_W'(old_dat);
         if (value_q < min_val_q) begin
            min_val_d = value_q;
         end
         if (value_q > max_val_q) begin
            max_val_d = value_q;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      if (bus.clear) begin
         state_d    = FILLING;
         fill_cnt_d = '0;
      end else begin
         case (state_q)
            FILLING: begin
               if (take) begin
                  fill_cnt_d = fill_cnt_q + 1'b1;
                  if (fill_cnt_q == LOG2_N'(N - 1)) begin
                     state_d = FULL;
                  end
               end
            end
            FULL:    state_d = FULL;
            default: state_d = FILLING;
         endcase
      end
   end

   always_ff @(posedge clk12MHz or negedge resetq) begin
      if (!resetq) begin
         state_q <= FILLING;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk12MHz or negedge resetq) begin
      if (!resetq) begin
         value_q    <= '0;
         div_cnt_q  <= '0;
         sum_q      <= '0;
         min_val_q  <= '1;
         max_val_q  <= '0;
         fill_cnt_q <= '0;
      end else begin
         value_q    <= bus.value;
         div_cnt_q  <= div_cnt_d;
         sum_q      <= sum_d;
         min_val_q  <= min_val_d;
         max_val_q  <= max_val_d;
         fill_cnt_q <= fill_cnt_d;
      end
   end

   assign bus.sample_tick = tick;
   assign bus.avg         = sum_q[SUM_W-1:LOG2_N];
   assign bus.avg_valid   = (state_q == FULL);
   assign bus.min_val     = min_val_q;
   assign bus.max_val     = max_val_q;
endmodule

// File: tb/tb_adc_sample_averager.sv
// Scenario tests plus a randomized run checked against a queue-based window model.
module tb_adc_sample_averager;
   localparam int W    = 10;
   localparam int LN   = 2;
   localparam int N    = 4;
   localparam int DIV  = 4;
   localparam int MAXV = 1023;

   logic clk12MHz = 1'b0;
   logic resetq   = 1'b0;
   always #5 clk12MHz = ~clk12MHz;

   adc_sample_averager_if #(.WIDTH(W)) bus ();

   adc_sample_averager #(
      .WIDTH      (W),
      .LOG2_N     (LN),
      .SAMPLE_DIV (DIV)
   ) dut (
      .clk12MHz (clk12MHz),
      .resetq   (resetq),
      .bus      (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: the window is simply the last N captured samples.
   int unsigned m_win[$];
   int unsigned m_value_q;
   int          m_phase;
   int unsigned m_min, m_max;
   int          m_count;

   task automatic model_reset();
      m_win.delete();
      for (int i = 0; i < N; i++) m_win.push_back(0);
      m_value_q = 0;
      m_phase   = 0;
      m_min     = MAXV;
      m_max     = 0;
      m_count   = 0;
   endtask

   function automatic int unsigned m_avg();
      int unsigned s = 0;
      foreach (m_win[i]) s += m_win[i];
      return s >> LN;
   endfunction

   // Advance one clock, update the model with the inputs seen at that edge,
   // then settle 1 time unit past the edge before anyone looks at outputs.
   task automatic cycle();
      bit tick_now;
      @(posedge clk12MHz);
      if (!resetq) begin
         model_reset();
      end else begin
         tick_now = (m_phase == DIV - 1);
         if (bus.clear) begin
            model_reset();
         end else begin
            if (tick_now) begin
               m_win.push_back(m_value_q);
               void'(m_win.pop_front());
               if (m_value_q < m_min) m_min = m_value_q;
               if (m_value_q > m_max) m_max = m_value_q;
               m_count++;
            end
            m_phase = (m_phase + 1) % DIV;
         end
         m_value_q = bus.value;
      end
      #1;
   endtask

   task automatic run_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         while (m_phase != DIV - 1) cycle();
         cycle();
      end
   endtask

   task automatic apply_reset(input int unsigned v);
      bus.clear = 1'b0;
      bus.value = W'(v);
      resetq    = 1'b0;
      cycle();
      cycle();
      @(negedge clk12MHz);
      resetq = 1'b1;
   endtask

   task automatic test_reset();
      int edges;
      bus.clear = 1'b0;
      bus.value = 10'd500;
      resetq    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         n_cmp++; if (bus.avg !== 10'd0) begin n_bad++; $display("FAIL reset_avg: got %0d want 0", bus.avg); end
         n_cmp++; if (bus.avg_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.avg_valid); end
         n_cmp++; if (bus.min_val !== 10'd1023) begin n_bad++; $display("FAIL reset_min: got %0d want 1023", bus.min_val); end
         n_cmp++; if (bus.max_val !== 10'd0) begin n_bad++; $display("FAIL reset_max: got %0d want 0", bus.max_val); end
         n_cmp++; if (bus.sample_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b want 0", bus.sample_tick); end
      end
      @(negedge clk12MHz);
      resetq = 1'b1;
      edges  = 0;
      for (int i = 1; i <= 3 * DIV && edges == 0; i++) begin
         cycle();
         if (bus.sample_tick === 1'b1) edges = i;
      end
      // The release cycle holds div_cnt=0, so the tick occupies the DIV-th cycle
      // counting that one, i.e. DIV-1 clock edges after release.
      n_cmp++; if (edges != DIV - 1) begin n_bad++; $display("FAIL reset_first_tick: edges=%0d want %0d", edges, DIV - 1); end
   endtask

   task automatic test_constant();
      apply_reset(100);
      run_ticks(1);
      n_cmp++; if (bus.avg !== 10'd25) begin n_bad++; $display("FAIL const_avg1: got %0d want 25", bus.avg); end
      n_cmp++; if (bus.avg_valid !== 1'b0) begin n_bad++; $display("FAIL const_valid1: got %b want 0", bus.avg_valid); end
      run_ticks(2);
      n_cmp++; if (bus.avg !== 10'd75) begin n_bad++; $display("FAIL const_avg3: got %0d want 75", bus.avg); end
      n_cmp++; if (bus.avg_valid !== 1'b0) begin n_bad++; $display("FAIL const_valid3: got %b want 0", bus.avg_valid); end
      run_ticks(1);
      n_cmp++; if (bus.avg !== 10'd100) begin n_bad++; $display("FAIL const_avg4: got %0d want 100", bus.avg); end
      n_cmp++; if (bus.avg_valid !== 1'b1) begin n_bad++; $display("FAIL const_valid4: got %b want 1", bus.avg_valid); end
   endtask

   task automatic test_sliding();
      apply_reset(0);
      run_ticks(1);
      for (int v = 4; v <= 12; v += 4) begin
         bus.value = W'(v);
         run_ticks(1);
      end
      n_cmp++; if (bus.avg !== 10'd6) begin n_bad++; $display("FAIL slide_avg6: got %0d want 6", bus.avg); end
      bus.value = 10'd16;
      run_ticks(1);
      n_cmp++; if (bus.avg !== 10'd10) begin n_bad++; $display("FAIL slide_avg10: got %0d want 10", bus.avg); end
      n_cmp++; if (bus.min_val !== 10'd0) begin n_bad++; $display("FAIL slide_min: got %0d want 0", bus.min_val); end
      n_cmp++; if (bus.max_val !== 10'd16) begin n_bad++; $display("FAIL slide_max: got %0d want 16", bus.max_val); end
   endtask

   task automatic test_full_scale();
      apply_reset(MAXV);
      run_ticks(4);
      n_cmp++; if (bus.avg !== 10'd1023) begin n_bad++; $display("FAIL full_avg_max: got %0d want 1023", bus.avg); end
      n_cmp++; if (bus.avg_valid !== 1'b1) begin n_bad++; $display("FAIL full_valid: got %b want 1", bus.avg_valid); end
      bus.value = 10'd0;
      run_ticks(4);
      n_cmp++; if (bus.avg !== 10'd0) begin n_bad++; $display("FAIL full_avg_zero: got %0d want 0", bus.avg); end
      n_cmp++; if (bus.min_val !== 10'd0) begin n_bad++; $display("FAIL full_min: got %0d want 0", bus.min_val); end
      n_cmp++; if (bus.max_val !== 10'd1023) begin n_bad++; $display("FAIL full_max: got %0d want 1023", bus.max_val); end
   endtask

   task automatic test_clear_on_tick();
      int edges;
      apply_reset(300);
      run_ticks(2);
      while (m_phase != DIV - 1) cycle();
      n_cmp++; if (bus.sample_tick !== 1'b1) begin n_bad++; $display("FAIL clr_tick_cycle: got %b want 1", bus.sample_tick); end
      bus.clear = 1'b1;
      cycle();
      bus.clear = 1'b0;
      n_cmp++; if (bus.avg !== 10'd0) begin n_bad++; $display("FAIL clr_avg: got %0d want 0", bus.avg); end
      n_cmp++; if (bus.avg_valid !== 1'b0) begin n_bad++; $display("FAIL clr_valid: got %b want 0", bus.avg_valid); end
      n_cmp++; if (bus.min_val !== 10'd1023) begin n_bad++; $display("FAIL clr_min: got %0d want 1023", bus.min_val); end
      n_cmp++; if (bus.max_val !== 10'd0) begin n_bad++; $display("FAIL clr_max: got %0d want 0", bus.max_val); end
      n_cmp++; if (bus.sample_tick !== 1'b0) begin n_bad++; $display("FAIL clr_no_tick: got %b want 0", bus.sample_tick); end
      edges = 0;
      for (int i = 1; i <= 3 * DIV && edges == 0; i++) begin
         cycle();
         if (bus.sample_tick === 1'b1) edges = i;
      end
      // Tick lands DIV cycles after the clear cycle, i.e. DIV-1 edges after the clear edge.
      n_cmp++; if (edges != DIV - 1) begin n_bad++; $display("FAIL clr_next_tick: edges=%0d want %0d", edges, DIV - 1); end
      cycle();
      n_cmp++; if (bus.avg !== 10'd75) begin n_bad++; $display("FAIL clr_refill_avg: got %0d want 75", bus.avg); end
   endtask

   task automatic test_async_reset();
      apply_reset(700);
      run_ticks(2);
      cycle();
      #2;
      resetq = 1'b0;
      #1;
      n_cmp++; if (bus.avg !== 10'd0) begin n_bad++; $display("FAIL arst_avg: got %0d want 0", bus.avg); end
      n_cmp++; if (bus.min_val !== 10'd1023) begin n_bad++; $display("FAIL arst_min: got %0d want 1023", bus.min_val); end
      n_cmp++; if (bus.max_val !== 10'd0) begin n_bad++; $display("FAIL arst_max: got %0d want 0", bus.max_val); end
      n_cmp++; if (bus.avg_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %b want 0", bus.avg_valid); end
      cycle();
      @(negedge clk12MHz);
      resetq = 1'b1;
      run_ticks(1);
      n_cmp++; if (bus.avg !== 10'd175) begin n_bad++; $display("FAIL arst_history_gone: got %0d want 175", bus.avg); end
   endtask

   task automatic test_random();
      apply_reset($urandom_range(0, MAXV));
      for (int i = 0; i < 400; i++) begin
         bus.value = W'($urandom_range(0, MAXV));
         bus.clear = ($urandom_range(0, 59) == 0);
         cycle();
         n_cmp++; if (bus.sample_tick !== (m_phase == DIV - 1)) begin n_bad++; $display("FAIL rnd_tick[%0d]: got %b want %b", i, bus.sample_tick, (m_phase == DIV - 1)); end
         n_cmp++; if (bus.avg !== W'(m_avg())) begin n_bad++; $display("FAIL rnd_avg[%0d]: got %0d want %0d", i, bus.avg, m_avg()); end
         n_cmp++; if (bus.avg_valid !== (m_count >= N)) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, bus.avg_valid, (m_count >= N)); end
         n_cmp++; if (bus.min_val !== W'(m_min)) begin n_bad++; $display("FAIL rnd_min[%0d]: got %0d want %0d", i, bus.min_val, m_min); end
         n_cmp++; if (bus.max_val !== W'(m_max)) begin n_bad++; $display("FAIL rnd_max[%0d]: got %0d want %0d", i, bus.max_val, m_max); end
      end
      bus.clear = 1'b0;
   endtask

   initial begin
      bus.value = '0;
      bus.clear = 1'b0;
      model_reset();
      test_reset();
      test_constant();
      test_sliding();
      test_full_scale();
      test_clear_on_tick();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
